// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - opcode/func encodings, FSM states and stall arbitration for hazard_ctrl
package hazard_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_HOLD1 = 1'b1
    } hazard_state_t;

    // Stall cycles demanded by the hazard classes; the longest requirement wins.
    function automatic logic [1:0] hazard_stalls(input logic load_use,
                                                 input logic br_alu,
                                                 input logic br_load,
                                                 input logic br_mem_load);
        if (br_load)
            return 2'd2;
        else if (load_use || br_alu || br_mem_load)
            return 2'd1;
        else
            return 2'd0;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - decode-stage interlock bus between pipeline registers and hazard_ctrl
// Signals: id_op/id_func/id_rs/id_rt (ID fields), ex_dst/ex_reg_write/ex_mem_read (ID/EX),
//          mem_dst/mem_reg_write/mem_mem_read (EX/MEM), mem_wait; outputs pc_write, if_id_write,
//          control_sel, forward_c, forward_d, and stall_cycles when HAZARD_PERF_EN is defined.
// Modports: master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int OP_W   = 6
`ifdef HAZARD_PERF_EN
    , parameter int PERF_W = 32
`endif
);
    logic [OP_W-1:0]   id_op;
    logic [OP_W-1:0]   id_func;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] ex_dst;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [REG_AW-1:0] mem_dst;
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic              mem_wait;
    logic              pc_write;
    logic              if_id_write;
    logic              control_sel;
    logic              forward_c;
    logic              forward_d;
`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cycles;
`endif

    modport master (
        output id_op, id_func, id_rs, id_rt,
        output ex_dst, ex_reg_write, ex_mem_read,
        output mem_dst, mem_reg_write, mem_mem_read, mem_wait,
        input  pc_write, if_id_write, control_sel, forward_c, forward_d
`ifdef HAZARD_PERF_EN
        , input stall_cycles
`endif
    );

    modport slave (
        input  id_op, id_func, id_rs, id_rt,
        input  ex_dst, ex_reg_write, ex_mem_read,
        input  mem_dst, mem_reg_write, mem_mem_read, mem_wait,
        output pc_write, if_id_write, control_sel, forward_c, forward_d
`ifdef HAZARD_PERF_EN
        , output stall_cycles
`endif
    );

endinterface

// File: rtl/hazard_cmp.sv
// rtl/hazard_cmp.sv - destination-vs-source register match with $0 exclusion
// Ports: dst, reg_write (producer); rs, rt, uses_rs, uses_rt (consumer in ID); match out.
module hazard_cmp #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] dst,
    input  logic              reg_write,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic              uses_rs,
    input  logic              uses_rt,
    output logic              match
);

    assign match = (dst != '0) && reg_write &&
                   ((uses_rs && (dst == rs)) || (uses_rt && (dst == rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - decode-stage interlock: load-use/branch stalls, bubbles, branch-compare forwarding
// Ports: clk, reset (sync, active-high), bus (hazard_ctrl_if.slave) carrying ID, ID/EX and EX/MEM
//        fields plus mem_wait in, and pc_write, if_id_write, control_sel, forward_c, forward_d out.
// Build option: HAZARD_PERF_EN adds bus.stall_cycles, a wrapping count of stall cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int OP_W   = 6
`ifdef HAZARD_PERF_EN
    , parameter int PERF_W = 32
`endif
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);

    hazard_state_t state_q, state_d;

    logic       is_br, uses_rs, uses_rt, is_rtype;
    logic       exm, memm;
    logic       fwd_c_raw, fwd_d_raw;
    logic       stall;
    logic [1:0] stall_need;

    // Instruction class decode for the instruction sitting in ID.
    always_comb begin
        is_rtype = (bus.id_op == OP_W'(OP_RTYPE));
        is_br    = (bus.id_op == OP_W'(OP_BEQ)) || (bus.id_op == OP_W'(OP_BNE)) ||
                   (is_rtype && (bus.id_func == OP_W'(FN_JR)));
        uses_rs  = !((bus.id_op == OP_W'(OP_J)) || (bus.id_op == OP_W'(OP_JAL)) ||
                     (bus.id_op == OP_W'(OP_LUI)));
        uses_rt  = (is_rtype && (bus.id_func != OP_W'(FN_JR))) ||
                   (bus.id_op == OP_W'(OP_BEQ)) || (bus.id_op == OP_W'(OP_BNE)) ||
                   (bus.id_op == OP_W'(OP_SW));
    end

    hazard_cmp #(.REG_AW(REG_AW)) u_cmp_ex (
        .dst      (bus.ex_dst),
        .reg_write(bus.ex_reg_write),
        .rs       (bus.id_rs),
        .rt       (bus.id_rt),
        .uses_rs  (uses_rs),
        .uses_rt  (uses_rt),
        .match    (exm)
    );

    hazard_cmp #(.REG_AW(REG_AW)) u_cmp_mem (
        .dst      (bus.mem_dst),
        .reg_write(bus.mem_reg_write),
        .rs       (bus.id_rs),
        .rt       (bus.id_rt),
        .uses_rs  (uses_rs),
        .uses_rt  (uses_rt),
        .match    (memm)
    );

    assign stall_need = hazard_stalls(bus.ex_mem_read && exm,
                                      is_br && exm && !bus.ex_mem_read,
                                      is_br && exm && bus.ex_mem_read,
                                      is_br && bus.mem_mem_read && memm);

    // Only ALU results are available in EX/MEM; a load there has no data yet.
    assign fwd_c_raw = is_br && bus.mem_reg_write && !bus.mem_mem_read &&
                       (bus.mem_dst != '0) && (bus.mem_dst == bus.id_rs);
    assign fwd_d_raw = is_br && bus.mem_reg_write && !bus.mem_mem_read &&
                       (bus.mem_dst != '0) && (bus.mem_dst == bus.id_rt);

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (stall_need != 2'd0)
                    stall = 1'b1;
                if (stall_need == 2'd2)
                    state_d = ST_HOLD1;
            end
            ST_HOLD1: begin
                stall   = 1'b1;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        // A memory wait freezes the whole pipeline, including any pending hold.
        if (bus.mem_wait)
            state_d = state_q;

        bus.pc_write    = 1'b1;
        bus.if_id_write = 1'b1;
        bus.control_sel = 1'b1;
        bus.forward_c   = fwd_c_raw;
        bus.forward_d   = fwd_d_raw;
        if (reset) begin
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
            bus.control_sel = 1'b0;
            bus.forward_c   = 1'b0;
            bus.forward_d   = 1'b0;
        end else if (bus.mem_wait) begin
            // Frozen, not bubbled: the instruction in ID keeps its control word.
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
        end else if (stall) begin
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
            bus.control_sel = 1'b0;
            bus.forward_c   = 1'b0;
            bus.forward_d   = 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset)
            stall_q <= '0;
        else if (!bus.mem_wait && !bus.pc_write)
            stall_q <= stall_q + PERF_W'(1);
    end

    assign bus.stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed-vector bench for hazard_ctrl
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if bus ();

    hazard_ctrl dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    localparam logic [5:0] FN_ADD = 6'b100000;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt);
        bus.id_op   = op;
        bus.id_func = fn;
        bus.id_rs   = rs;
        bus.id_rt   = rt;
    endtask

    task automatic set_ex(input logic [4:0] dst, input logic rw, input logic mr);
        bus.ex_dst       = dst;
        bus.ex_reg_write = rw;
        bus.ex_mem_read  = mr;
    endtask

    task automatic set_mem(input logic [4:0] dst, input logic rw, input logic mr);
        bus.mem_dst       = dst;
        bus.mem_reg_write = rw;
        bus.mem_mem_read  = mr;
    endtask

    // Expected vector order: {pc_write, if_id_write, control_sel, forward_c, forward_d}
    task automatic check(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        #1;
        obs = {bus.pc_write, bus.if_id_write, bus.control_sel, bus.forward_c, bus.forward_d};
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic check_perf(input string tag, input int exp);
        vectors++;
        assert (bus.stall_cycles === 32'(exp)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, bus.stall_cycles, exp);
        end
    endtask
`endif

    initial begin
        reset        = 1'b1;
        bus.mem_wait = 1'b0;
        set_id(OP_RTYPE, 6'b0, 5'd0, 5'd0);
        set_ex(5'd0, 1'b0, 1'b0);
        set_mem(5'd0, 1'b0, 1'b0);
        step();
        check("reset_outputs", 5'b00000);
        step();
        reset = 1'b0;
`ifdef HAZARD_PERF_EN
        check_perf("perf_after_reset", 0);
`endif
        check("idle", 5'b11100);

        // lw $2 in EX, add $3,$2,$4 in ID
        set_id(OP_RTYPE, FN_ADD, 5'd2, 5'd4);
        set_ex(5'd2, 1'b1, 1'b1);
        check("load_use_stall", 5'b00000);
        step();
        set_ex(5'd0, 1'b0, 1'b0);
        set_mem(5'd2, 1'b1, 1'b1);
        check("load_use_resume", 5'b11100);
        step();
        set_mem(5'd0, 1'b0, 1'b0);

        // lw $2 in EX, beq $2,$5 in ID: two stall cycles
        set_id(OP_BEQ, 6'b0, 5'd2, 5'd5);
        set_ex(5'd2, 1'b1, 1'b1);
        check("br_load_stall1", 5'b00000);
        step();
        set_ex(5'd0, 1'b0, 1'b0);
        set_mem(5'd2, 1'b1, 1'b1);
        check("br_load_hold1", 5'b00000);
        step();
        set_mem(5'd0, 1'b0, 1'b0);
        check("br_load_done", 5'b11100);
`ifdef HAZARD_PERF_EN
        check_perf("perf_three", 3);
`endif

        // add $6 in EX, beq $6,$7 in ID: one stall then forward from EX/MEM
        step();
        set_id(OP_BEQ, 6'b0, 5'd6, 5'd7);
        set_ex(5'd6, 1'b1, 1'b0);
        check("br_alu_stall", 5'b00000);
        step();
        set_ex(5'd0, 1'b0, 1'b0);
        set_mem(5'd6, 1'b1, 1'b0);
        check("br_alu_fwd_c", 5'b11110);
        set_id(OP_BNE, 6'b0, 5'd7, 5'd6);
        check("bne_fwd_d", 5'b11101);

        // branch operand still loading in EX/MEM: one stall, no forward
        set_id(OP_BEQ, 6'b0, 5'd3, 5'd9);
        set_mem(5'd3, 1'b1, 1'b1);
        check("br_mem_load", 5'b00000);
        set_mem(5'd0, 1'b0, 1'b0);

        // register 0 never hazards or forwards
        set_id(OP_RTYPE, FN_ADD, 5'd0, 5'd0);
        set_ex(5'd0, 1'b1, 1'b1);
        check("reg0_no_stall", 5'b11100);
        set_id(OP_BEQ, 6'b0, 5'd0, 5'd0);
        set_ex(5'd0, 1'b0, 1'b0);
        set_mem(5'd0, 1'b1, 1'b0);
        check("reg0_no_fwd", 5'b11100);
        set_mem(5'd0, 1'b0, 1'b0);

        // operand-usage decode corners
        set_id(OP_RTYPE, FN_JR, 5'd9, 5'd8);
        set_ex(5'd9, 1'b1, 1'b0);
        check("jr_rs_stall", 5'b00000);
        set_ex(5'd8, 1'b1, 1'b0);
        check("jr_rt_ignored", 5'b11100);
        set_id(OP_J, 6'b0, 5'd8, 5'd0);
        set_ex(5'd8, 1'b1, 1'b1);
        check("j_no_rs", 5'b11100);
        set_id(OP_SW, 6'b0, 5'd1, 5'd8);
        check("sw_rt_load_use", 5'b00000);
        set_id(OP_LUI, 6'b0, 5'd0, 5'd8);
        check("lui_no_rt", 5'b11100);
        set_ex(5'd0, 1'b0, 1'b0);

        // mem_wait held three cycles during HOLD1
        step();
        set_id(OP_BEQ, 6'b0, 5'd2, 5'd5);
        set_ex(5'd2, 1'b1, 1'b1);
        check("mw_stall1", 5'b00000);
        step();
        set_ex(5'd0, 1'b0, 1'b0);
        set_mem(5'd2, 1'b1, 1'b1);
        bus.mem_wait = 1'b1;
        check("mw_cycle1", 5'b00100);
        step();
        check("mw_cycle2", 5'b00100);
        step();
        check("mw_cycle3", 5'b00100);
        step();
        bus.mem_wait = 1'b0;
        check("mw_release_bubble", 5'b00000);
        step();
        set_mem(5'd0, 1'b0, 1'b0);
        check("mw_back_to_run", 5'b11100);

        // reset pulse while in HOLD1
        step();
        set_ex(5'd2, 1'b1, 1'b1);
        check("rst_stall1", 5'b00000);
        step();
        set_ex(5'd0, 1'b0, 1'b0);
        reset = 1'b1;
        check("rst_during_hold", 5'b00000);
        step();
        reset = 1'b0;
        check("rst_back_to_run", 5'b11100);
`ifdef HAZARD_PERF_EN
        check_perf("perf_cleared", 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
